// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, request kinds, word-index helper.
package dm_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

    // Byte address to word index; callers keep the low ADDR_WIDTH bits, which wraps by depth.
    function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/dm_array.sv
// Word storage for dm_responder: synchronous write, asynchronous read, no reset.
module dm_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dm_responder.sv
// Data-memory slave that latches one request, waits WAIT_STATES cycles, then completes with a dm_ready pulse.
// Optional DM_ALIGN_CHECK_EN adds dm_error and suppresses misaligned accesses.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dm_read,
    input  logic                  dm_write,
    input  logic [31:0]           read_address_to_dm,
    input  logic [31:0]           write_address_to_dm,
    input  logic [DATA_WIDTH-1:0] data_to_dm,
    output logic [DATA_WIDTH-1:0] data_from_dm,
    output logic                  dm_ready,
    output logic                  dm_busy
`ifdef DM_ALIGN_CHECK_EN
    ,
    output logic                  dm_error
`endif
);

    logic [1:0]            state;
    logic [3:0]            wait_cnt;
    logic                  lat_kind;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [DATA_WIDTH-1:0] lat_data;
    logic                  lat_misaligned;

    logic                  req;
    logic                  in_kind;
    logic [31:0]           in_addr;
    logic [29:0]           in_word;
    logic [ADDR_WIDTH-1:0] in_idx;
    logic                  in_misaligned;

    logic                  cmp_kind;
    logic [ADDR_WIDTH-1:0] cmp_idx;
    logic                  cmp_misaligned;
    logic                  enter_done;

    logic                  arr_we;
    logic [DATA_WIDTH-1:0] arr_rdata;

    // Write wins when both request lines are high, so its address is the one latched.
    assign req     = dm_read | dm_write;
    assign in_kind = dm_write ? REQ_WR : REQ_RD;
    assign in_addr = dm_write ? write_address_to_dm : read_address_to_dm;
    assign in_word = word_index(in_addr);
    assign in_idx  = in_word[ADDR_WIDTH-1:0];

`ifdef DM_ALIGN_CHECK_EN
    assign in_misaligned = (in_addr[1:0] != 2'b00);
    assign dm_error      = (state == ST_DONE) && lat_misaligned;
`else
    assign in_misaligned = 1'b0;
`endif

    // With zero wait states DONE is entered straight from IDLE, before the latch holds the request.
    assign cmp_kind       = (state == ST_IDLE) ? in_kind       : lat_kind;
    assign cmp_idx        = (state == ST_IDLE) ? in_idx        : lat_idx;
    assign cmp_misaligned = (state == ST_IDLE) ? in_misaligned : lat_misaligned;

    assign enter_done = ((state == ST_IDLE) && req && (WAIT_STATES == 0))
                     || ((state == ST_WAIT) && (wait_cnt == 4'd0));

    assign arr_we   = (state == ST_DONE) && (lat_kind == REQ_WR) && !lat_misaligned;
    assign dm_ready = (state == ST_DONE);
    assign dm_busy  = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            lat_kind       <= REQ_RD;
            lat_idx        <= '0;
            lat_data       <= '0;
            lat_misaligned <= 1'b0;
            data_from_dm   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        lat_kind       <= in_kind;
                        lat_idx        <= in_idx;
                        lat_data       <= data_to_dm;
                        lat_misaligned <= in_misaligned;
                        if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (enter_done && (cmp_kind == REQ_RD) && !cmp_misaligned) begin
                data_from_dm <= arr_rdata;
            end
        end
    end

    dm_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (lat_idx),
        .wdata (lat_data),
        .raddr (cmp_idx),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder: one instance with two wait states, one with none.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] ra    [2];
    logic [31:0] wa    [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic        rdy   [2];
    logic        busy  [2];
`ifdef DM_ALIGN_CHECK_EN
    logic        derr  [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .WAIT_STATES(2)
    ) u_dut_ws2 (
        .clk                 (clk),
        .reset               (reset),
        .dm_read             (rd[0]),
        .dm_write            (wr[0]),
        .read_address_to_dm  (ra[0]),
        .write_address_to_dm (wa[0]),
        .data_to_dm          (wd[0]),
        .data_from_dm        (rdata[0]),
        .dm_ready            (rdy[0]),
        .dm_busy             (busy[0])
`ifdef DM_ALIGN_CHECK_EN
        ,
        .dm_error            (derr[0])
`endif
    );

    dm_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .WAIT_STATES(0)
    ) u_dut_ws0 (
        .clk                 (clk),
        .reset               (reset),
        .dm_read             (rd[1]),
        .dm_write            (wr[1]),
        .read_address_to_dm  (ra[1]),
        .write_address_to_dm (wa[1]),
        .data_to_dm          (wd[1]),
        .data_from_dm        (rdata[1]),
        .dm_ready            (rdy[1]),
        .dm_busy             (busy[1])
`ifdef DM_ALIGN_CHECK_EN
        ,
        .dm_error            (derr[1])
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, measure edges from acceptance to dm_ready, capture outputs, confirm the pulse ends.
    task automatic do_req(input int d, input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] wdat, input int exp_lat, input string tag,
                          output logic [31:0] dout, output logic err);
        int lat;
        bit seen;
        rd[d] = r;
        wr[d] = w;
        ra[d] = addr;
        wa[d] = addr;
        wd[d] = wdat;
        @(posedge clk);
        #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        ra[d] = $urandom;
        wa[d] = $urandom;
        wd[d] = $urandom;
        check({tag, "_busy"}, 64'(busy[d]), 64'd1);
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rdy[d]) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, seen ? 64'(lat) : 64'd0, 64'(exp_lat));
        dout = rdata[d];
`ifdef DM_ALIGN_CHECK_EN
        err = derr[d];
`else
        err = 1'b0;
`endif
        @(posedge clk);
        #1;
        check({tag, "_rdy_off"}, 64'(rdy[d]), 64'd0);
    endtask

    initial begin
        logic [31:0] dout;
        logic        err;
        int          pulses;

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
            ra[d] = '0;
            wa[d] = '0;
            wd[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", 64'(rdata[0]), 64'd0);
        check("rst_ready", 64'(rdy[0]), 64'd0);
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_data_ws0", 64'(rdata[1]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, "wr_10", dout, err);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 3, "rd_10", dout, err);
        check("rd_10_data", 64'(dout), 64'hDEADBEEF);
`ifdef DM_ALIGN_CHECK_EN
        check("rd_10_err", 64'(err), 64'd0);
`endif

        do_req(1, 1'b0, 1'b1, 32'h4, 32'h1234, 1, "ws0_wr", dout, err);
        do_req(1, 1'b1, 1'b0, 32'h4, 32'h0, 1, "ws0_rd", dout, err);
        check("ws0_rd_data", 64'(dout), 64'h00001234);

        do_req(0, 1'b0, 1'b1, 32'h8, 32'h77, 3, "wr_77", dout, err);
        do_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 3, "rd_77", dout, err);
        check("rd_77_data", 64'(dout), 64'h77);
        do_req(0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 3, "both", dout, err);
        check("both_data_held", 64'(dout), 64'h77);
        pulses = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rdy[0]) pulses++;
        end
        check("both_single_ready", 64'(pulses), 64'd0);
        check("both_data_after", 64'(rdata[0]), 64'h77);
        do_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 3, "rd_a5", dout, err);
        check("rd_a5_data", 64'(dout), 64'hA5A5A5A5);

        do_req(0, 1'b0, 1'b1, 32'h20, 32'h1111, 3, "wr_1111", dout, err);
        wr[0] = 1'b1;
        wa[0] = 32'h20;
        wd[0] = 32'hCAFE;
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        check("cafe_busy", 64'(busy[0]), 64'd1);
        @(posedge clk);
        #1;
        check("cafe_wait_rdy", 64'(rdy[0]), 64'd0);
        reset = 1'b1;
        #1;
        check("cafe_rst_rdy", 64'(rdy[0]), 64'd0);
        check("cafe_rst_busy", 64'(busy[0]), 64'd0);
        check("cafe_rst_data", 64'(rdata[0]), 64'd0);
        @(posedge clk);
        #1;
        check("cafe_rst_rdy2", 64'(rdy[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 3, "rd_20", dout, err);
        check("rd_20_data", 64'(dout), 64'h1111);

        do_req(0, 1'b0, 1'b1, 32'h400, 32'h55, 3, "wr_400", dout, err);
        do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 3, "rd_0", dout, err);
        check("wrap_data", 64'(dout), 64'h55);

        do_req(0, 1'b0, 1'b1, 32'h10, 32'h4242, 3, "wr_4242", dout, err);
        do_req(0, 1'b0, 1'b1, 32'h13, 32'h99, 3, "wr_13", dout, err);
`ifdef DM_ALIGN_CHECK_EN
        check("wr_13_err", 64'(err), 64'd1);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 3, "rd_10b", dout, err);
        check("align_word_kept", 64'(dout), 64'h4242);
        check("rd_10b_err", 64'(err), 64'd0);
`else
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 3, "rd_10b", dout, err);
        check("trunc_word_written", 64'(dout), 64'h99);
`endif

        // A read held high completes every four edges with two wait states.
        rd[0] = 1'b1;
        ra[0] = 32'h20;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rdy[0]) pulses++;
        end
        rd[0] = 1'b0;
        check("held_pulses", 64'(pulses), 64'd2);
        check("held_data", 64'(rdata[0]), 64'h1111);
        @(posedge clk);
        #1;
        check("held_idle_busy", 64'(busy[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Word-addressed data-memory slave; the responder end of the CPU data-memory port (dm_read/dm_write, split read/write addresses, data_to_dm, data_from_dm).
- Latches one request at a time and waits a programmable number of cycles.
- Commits a write, or returns read data, together with a one-cycle dm_ready pulse.
- Sits between the cpu and the system memory map; used in place of a zero-latency array to model slow memory.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 8, word-index width; depth = 2**ADDR_WIDTH words.
- WAIT_STATES, 2, extra cycles inserted between acceptance and completion; 0..15 is legal.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- dm_read  input  1  read request.
- dm_write  input  1  write request.
- read_address_to_dm  input  32  byte address for a read.
- write_address_to_dm  input  32  byte address for a write.
- data_to_dm  input  DATA_WIDTH  write data.
- data_from_dm  output  DATA_WIDTH  read data; held until the next read completes.
- dm_ready  output  1  one-cycle completion pulse.
- dm_busy  output  1  high while a request is latched and not yet complete.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high.
  - On reset: state=IDLE, data_from_dm=0, dm_ready=0, dm_busy=0, wait counter=0.
  - The memory array is not reset; its contents are undefined until written.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - A request is accepted on any edge where dm_read|dm_write=1.
  - On acceptance, latch the kind, the word index (address bits [ADDR_WIDTH+1:2]) and data_to_dm.
  - If WAIT_STATES>0, go to WAIT with counter=WAIT_STATES-1; otherwise go to DONE.
- WAIT:
  - The counter decrements each cycle; go to DONE when it reaches 0.
  - Request inputs are ignored and may change freely.
- DONE (one cycle):
  - dm_ready=1.
  - A write commits to the array on this edge.
  - For a read, data_from_dm is updated on the edge entering DONE, so it is valid while dm_ready=1.
  - Next state is IDLE. No request is accepted in DONE.
- Latency and throughput:
  - Latency from the acceptance edge to dm_ready high is WAIT_STATES+1 cycles.
  - Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- dm_busy is 1 in WAIT and DONE, and 0 in IDLE.
- dm_read and dm_write both asserted at acceptance: the write wins, the read is dropped, and data_from_dm is unchanged.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo the depth.
- Address bits [1:0] are ignored unless the optional feature is compiled in.
- Read-after-write to the same word in consecutive transactions returns the new data; the write has committed before the next acceptance.
- Reset asserted in WAIT or DONE before the committing edge: the pending write is discarded, the array is unchanged, and no dm_ready is produced.
- A request held high across DONE is re-accepted in the following IDLE cycle as a new transaction.

Optional Feature:
- Macro: DM_ALIGN_CHECK_EN.
- Defined:
  - Adds output dm_error (1 bit, reset 0).
  - An accepted request whose latched address has bits [1:0]!=0 still runs the full WAIT/DONE timing.
  - In DONE it asserts dm_error=1 alongside dm_ready. A write is suppressed; a read leaves data_from_dm unchanged.
- Undefined: no dm_error port exists, and a misaligned address is silently truncated to its word.

Decomposition:
- Shared package dm_pkg holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2).
  - Request-kind constants (REQ_RD, REQ_WR).
  - The word-index slice helper (function or macro).
- One sub-module, dm_array: synchronous-write, asynchronous-read storage of 2**ADDR_WIDTH x DATA_WIDTH words with no reset. The FSM, counter and request latch stay in dm_responder.

Test Plan:
- Reset, then write 0xDEADBEEF to address 0x10 with WAIT_STATES=2 -> dm_ready pulses exactly 3 cycles after acceptance; a read of 0x10 then returns 0xDEADBEEF with dm_ready high.
- WAIT_STATES=0: write 0x1234 to 0x4, then immediately read 0x4 -> each dm_ready arrives 1 cycle after its acceptance; data_from_dm=0x00001234.
- dm_read=dm_write=1 at address 0x8 with data_to_dm=0xA5A5A5A5, where data_from_dm was previously 0x77 -> the word is written, data_from_dm stays 0x77, and a single dm_ready occurs.
- Write 0xCAFE to 0x20, then assert reset during WAIT -> no dm_ready; all outputs are 0 immediately; a later read of 0x20 returns the value written before the test (0x1111), not 0xCAFE.
- ADDR_WIDTH=8: write 0x55 to byte address 0x400 -> a read of 0x0 returns 0x55 (wrap-around).
- With DM_ALIGN_CHECK_EN: write 0x99 to 0x13 -> dm_error=1 together with dm_ready, and word 0x10 is unchanged. Without the macro, the same write stores 0x99 at word 0x10.
